// File: rtl/prt_dptx_act_seq.sv
// prt_dptx_act_seq: sequences an MST time-slot allocation change on the DP TX
// control register block. One accepted request produces four ordered writes on
// the message egress port: time slots, ACT mask, ACT set, then ACT clear.
// ACT stays set until the link layer reports that the ACT sequence was sent.
//
// Optional feature macro: PRT_DPTX_ACT_SEQ_TIMEOUT_EN
//   defined   : HOLD also exits after P_TIMEOUT cycles without ACT_DONE_IN;
//               ERR_OUT is set and stays set until the next accepted request.
//   undefined : HOLD waits for ACT_DONE_IN indefinitely; ERR_OUT is tied low.
module prt_dptx_act_seq #(
  parameter int P_MSG_IDX = 5,
  parameter int P_MSG_DAT = 16,
  parameter int P_ACT_MIN = 8,
  parameter int P_TIMEOUT = 4095
) (
  input  logic                 CLK_IN,
  input  logic                 RST_IN,
  input  logic                 REQ_IN,
  input  logic [5:0]           REQ_VC0_TS_IN,
  input  logic [5:0]           REQ_VC1_TS_IN,
  input  logic                 ACT_DONE_IN,
  output logic                 BUSY_OUT,
  output logic                 DONE_OUT,
  output logic                 ERR_OUT,
  output logic [P_MSG_IDX-1:0] WR_IDX_OUT,
  output logic [P_MSG_DAT-1:0] WR_DAT_OUT,
  output logic                 WR_VLD_OUT,
  input  logic                 WR_RDY_IN
);

  // The counter covers both the ACT minimum and the timeout span.
  localparam int CNT_MAX = (P_ACT_MIN > P_TIMEOUT) ? P_ACT_MIN : P_TIMEOUT;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  typedef logic [CNT_W-1:0]     cnt_t;
  typedef logic [P_MSG_IDX-1:0] idx_t;
  typedef logic [P_MSG_DAT-1:0] dat_t;

  localparam cnt_t MIN_M1  = cnt_t'(P_ACT_MIN - 1);
  localparam idx_t IDX_ACT = idx_t'(1);
  localparam idx_t IDX_MSK = idx_t'(0);
  localparam idx_t IDX_TS  = idx_t'(2);
  localparam dat_t DAT_ACT = dat_t'(16'h0040);

  typedef enum logic [2:0] {
    S_IDLE, S_WR_TS, S_WR_MSK, S_WR_SET, S_HOLD, S_WR_CLR, S_FIN
  } state_t;

  state_t state;
  cnt_t   cnt;
  logic   done_q;
  logic   hs;
  logic   done_now;
  logic   min_ok;

  // A write completes on VLD&&RDY; a done pulse counts in the cycle it arrives.
  assign hs       = WR_VLD_OUT & WR_RDY_IN;
  assign done_now = done_q | ACT_DONE_IN;
  assign min_ok   = (cnt >= MIN_M1);

`ifdef PRT_DPTX_ACT_SEQ_TIMEOUT_EN
  localparam cnt_t TO_M1 = cnt_t'(P_TIMEOUT - 1);
  logic err_q;
  assign ERR_OUT = err_q;
`else
  assign ERR_OUT = 1'b0;
`endif

  // Sequencer: state plus every registered output, updated together so the
  // next write is already on the port in the cycle after a handshake.
  always_ff @(posedge CLK_IN or negedge RST_IN) begin
    if (!RST_IN) begin
      state      <= S_IDLE;
      cnt        <= '0;
      done_q     <= 1'b0;
      BUSY_OUT   <= 1'b0;
      DONE_OUT   <= 1'b0;
      WR_VLD_OUT <= 1'b0;
      WR_IDX_OUT <= '0;
      WR_DAT_OUT <= '0;
`ifdef PRT_DPTX_ACT_SEQ_TIMEOUT_EN
      err_q      <= 1'b0;
`endif
    end else begin
      DONE_OUT <= 1'b0;
      case (state)
        S_IDLE: begin
          if (REQ_IN) begin
            // Slots are captured straight into the time-slot write data.
            state      <= S_WR_TS;
            BUSY_OUT   <= 1'b1;
            WR_VLD_OUT <= 1'b1;
            WR_IDX_OUT <= IDX_TS;
            WR_DAT_OUT <= dat_t'({2'b00, REQ_VC1_TS_IN, 2'b00, REQ_VC0_TS_IN});
`ifdef PRT_DPTX_ACT_SEQ_TIMEOUT_EN
            err_q      <= 1'b0;
`endif
          end
        end
        S_WR_TS: begin
          if (hs) begin
            state      <= S_WR_MSK;
            WR_IDX_OUT <= IDX_MSK;
            WR_DAT_OUT <= DAT_ACT;
          end
        end
        S_WR_MSK: begin
          if (hs) begin
            state      <= S_WR_SET;
            WR_IDX_OUT <= IDX_ACT;
            WR_DAT_OUT <= DAT_ACT;
          end
        end
        S_WR_SET: begin
          if (hs) begin
            // Done seen on the set handshake itself is already kept.
            state      <= S_HOLD;
            cnt        <= '0;
            done_q     <= ACT_DONE_IN;
            WR_VLD_OUT <= 1'b0;
            WR_IDX_OUT <= '0;
            WR_DAT_OUT <= '0;
          end
        end
        S_HOLD: begin
          done_q <= done_now;
          if (cnt != '1) cnt <= cnt + 1'b1;
          if (min_ok && done_now) begin
            state      <= S_WR_CLR;
            WR_VLD_OUT <= 1'b1;
            WR_IDX_OUT <= IDX_ACT;
            WR_DAT_OUT <= '0;
          end
`ifdef PRT_DPTX_ACT_SEQ_TIMEOUT_EN
          else if (!done_now && cnt >= TO_M1) begin
            // Give up on the link layer but still clear ACT and finish.
            state      <= S_WR_CLR;
            err_q      <= 1'b1;
            WR_VLD_OUT <= 1'b1;
            WR_IDX_OUT <= IDX_ACT;
            WR_DAT_OUT <= '0;
          end
`endif
        end
        S_WR_CLR: begin
          if (hs) begin
            state      <= S_FIN;
            done_q     <= 1'b0;
            DONE_OUT   <= 1'b1;
            WR_VLD_OUT <= 1'b0;
            WR_IDX_OUT <= '0;
            WR_DAT_OUT <= '0;
          end
        end
        S_FIN: begin
          // Requests arriving here are dropped; IDLE only samples the next one.
          state    <= S_IDLE;
          BUSY_OUT <= 1'b0;
        end
        default: begin
          state      <= S_IDLE;
          BUSY_OUT   <= 1'b0;
          WR_VLD_OUT <= 1'b0;
        end
      endcase
    end
  end

endmodule
